// File: rtl/angle_rom_arb.sv
`timescale 1ns/1ps
// Three-way read arbiter in front of the angle ROM. Responses come back in grant
// order after a fixed latency, tracked by a small tag pipeline.
module angle_rom_arb #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter int unsigned DATA_WIDTH = 7,
    parameter int unsigned RD_LATENCY = 1,
    parameter string       ARB_MODE   = "RR"
) (
    input  logic                    clk,
    input  logic                    tb_rst,
    input  logic [2:0]              req_valid,
    input  logic [3*ADDR_WIDTH-1:0] req_addr,
    output logic [2:0]              req_ready,
    output logic [2:0]              rsp_valid,
    output logic [DATA_WIDTH-1:0]   rsp_data,
    output logic [ADDR_WIDTH-1:0]   rom_addr,
    input  logic [DATA_WIDTH-1:0]   rom_rd_data,
    output logic                    busy
);

    localparam int unsigned Depth   = 1 + RD_LATENCY;
    localparam bit          IsFixed = (ARB_MODE == "FIXED");

    logic [1:0]            last_grant_q, last_grant_d;
    logic [1:0]            grant_id;
    logic [1:0]            cand;
    logic                  hs;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [Depth-1:0]      tag_vld_q;
    logic [1:0]            tag_id_q [Depth];
    logic [2:0]            rsp_valid_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;

    always_comb begin
        grant_id = 2'd0;
        cand     = 2'd0;
        hs       = 1'b0;
        if (IsFixed) begin
            for (int i = 2; i >= 0; i--) begin
                if (req_valid[i]) begin
                    grant_id = 2'(i);
                    hs       = 1'b1;
                end
            end
        end else begin
            // Walk from the farthest candidate inward so the nearest one wins.
            for (int k = 3; k >= 1; k--) begin
                cand = 2'((int'(last_grant_q) + k) % 3);
                if (req_valid[cand]) begin
                    grant_id = cand;
                    hs       = 1'b1;
                end
            end
        end
        if (tb_rst) begin
            hs = 1'b0;
        end
        req_ready    = hs ? (3'b001 << grant_id) : 3'b000;
        last_grant_d = hs ? grant_id : last_grant_q;
        rom_addr_d   = hs ? req_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH] : rom_addr_q;
    end

    always_ff @(posedge clk or posedge tb_rst) begin
        if (tb_rst) begin
            last_grant_q <= 2'd2;
            rom_addr_q   <= '0;
            tag_vld_q    <= '0;
            for (int unsigned d = 0; d < Depth; d++) begin
                tag_id_q[d] <= 2'd0;
            end
            rsp_valid_q  <= 3'b000;
            rsp_data_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            rom_addr_q   <= rom_addr_d;
            tag_vld_q    <= {tag_vld_q[Depth-2:0], hs};
            tag_id_q[0]  <= grant_id;
            for (int unsigned d = 1; d < Depth; d++) begin
                tag_id_q[d] <= tag_id_q[d-1];
            end
            // The tag leaving the pipeline lines up with the ROM data for its address.
            rsp_valid_q <= tag_vld_q[Depth-1] ? (3'b001 << tag_id_q[Depth-1]) : 3'b000;
            if (tag_vld_q[Depth-1]) begin
                rsp_data_q <= rom_rd_data;
            end
        end
    end

    assign rom_addr  = rom_addr_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign busy      = (|tag_vld_q) | (|rsp_valid_q);

endmodule

// File: tb/tb_angle_rom_arb.sv
`timescale 1ns/1ps
// Bench for angle_rom_arb: three instances (RR/lat1, FIXED/lat1, RR/lat2) share one
// stimulus stream and are checked every cycle against a transaction-level model.
module tb_angle_rom_arb;

    localparam int AW = 12;
    localparam int DW = 7;

    logic          clk = 1'b0;
    logic          tb_rst = 1'b1;
    logic [2:0]    req_valid = 3'b000;
    logic [3*AW-1:0] req_addr = '0;

    logic [2:0]    rdy    [3];
    logic [2:0]    rv     [3];
    logic [DW-1:0] rd     [3];
    logic [AW-1:0] ra     [3];
    logic          bsy    [3];
    logic [DW-1:0] rom_q1 [3];
    logic [DW-1:0] rom_q2 [3];
    logic [DW-1:0] rom_rd [3];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;
    int cnt2   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    angle_rom_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .ARB_MODE("RR")) u_rr (
        .clk(clk), .tb_rst(tb_rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(rdy[0]), .rsp_valid(rv[0]), .rsp_data(rd[0]), .rom_addr(ra[0]),
        .rom_rd_data(rom_rd[0]), .busy(bsy[0])
    );
    angle_rom_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(1), .ARB_MODE("FIXED")) u_fx (
        .clk(clk), .tb_rst(tb_rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(rdy[1]), .rsp_valid(rv[1]), .rsp_data(rd[1]), .rom_addr(ra[1]),
        .rom_rd_data(rom_rd[1]), .busy(bsy[1])
    );
    angle_rom_arb #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LATENCY(2), .ARB_MODE("RR")) u_l2 (
        .clk(clk), .tb_rst(tb_rst), .req_valid(req_valid), .req_addr(req_addr),
        .req_ready(rdy[2]), .rsp_valid(rv[2]), .rsp_data(rd[2]), .rom_addr(ra[2]),
        .rom_rd_data(rom_rd[2]), .busy(bsy[2])
    );

    // Behavioural ROM: data = addr[6:0], one or two register stages.
    always_ff @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            rom_q1[i] <= ra[i][6:0];
            rom_q2[i] <= rom_q1[i];
        end
    end
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            rom_rd[i] = (i == 2) ? rom_q2[i] : rom_q1[i];
        end
    end

    always @(negedge clk) if (rv[0][2]) cnt2++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int lat_of(input int i);
        return (i == 2) ? 2 : 1;
    endfunction

    typedef struct {
        int inst;
        int hs;
        int due;
        int port;
        int data;
    } rec_t;

    rec_t       recs [$];
    int         lg      [3];
    logic [AW-1:0] exp_rom [3];
    logic [DW-1:0] exp_dat [3];
    int         m_g;
    int         m_p;
    logic [2:0] m_ev;
    logic       m_eb;
    rec_t       m_r;

    initial begin
        for (int i = 0; i < 3; i++) begin
            lg[i] = 2;
            exp_rom[i] = '0;
            exp_dat[i] = '0;
        end
    end

    // Transaction model: each grant becomes a record due 2+latency cycles later.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (tb_rst) begin
                lg[i] = 2;
                exp_rom[i] = '0;
                exp_dat[i] = '0;
                for (int j = recs.size() - 1; j >= 0; j--) begin
                    if (recs[j].inst == i) recs.delete(j);
                end
                chk("m_rst_ready", 32'(rdy[i]), 0);
                chk("m_rst_rsp_valid", 32'(rv[i]), 0);
                chk("m_rst_rsp_data", 32'(rd[i]), 0);
                chk("m_rst_rom_addr", 32'(ra[i]), 0);
                chk("m_rst_busy", 32'(bsy[i]), 0);
            end else begin
                m_g = -1;
                if (i == 1) begin
                    for (int p = 2; p >= 0; p--) if (req_valid[p]) m_g = p;
                end else begin
                    for (int k = 3; k >= 1; k--) begin
                        m_p = (lg[i] + k) % 3;
                        if (req_valid[m_p]) m_g = m_p;
                    end
                end
                chk("m_ready", 32'(rdy[i]), (m_g < 0) ? 0 : (1 << m_g));
                chk("m_rom_addr", 32'(ra[i]), 32'(exp_rom[i]));
                m_ev = 3'b000;
                m_eb = 1'b0;
                foreach (recs[j]) begin
                    if (recs[j].inst == i) begin
                        if (recs[j].due == cyc) begin
                            m_ev = 3'b001 << recs[j].port;
                            exp_dat[i] = DW'(recs[j].data);
                        end
                        if (recs[j].hs < cyc && cyc <= recs[j].due) m_eb = 1'b1;
                    end
                end
                chk("m_rsp_valid", 32'(rv[i]), 32'(m_ev));
                chk("m_rsp_data", 32'(rd[i]), 32'(exp_dat[i]));
                chk("m_busy", 32'(bsy[i]), 32'(m_eb));
                if (m_g >= 0) begin
                    lg[i] = m_g;
                    exp_rom[i] = req_addr[m_g*AW +: AW];
                    m_r.inst = i;
                    m_r.hs   = cyc;
                    m_r.due  = cyc + 2 + lat_of(i);
                    m_r.port = m_g;
                    m_r.data = int'(exp_rom[i][6:0]);
                    recs.push_back(m_r);
                end
            end
        end
        for (int j = recs.size() - 1; j >= 0; j--) begin
            if (recs[j].due < cyc) recs.delete(j);
        end
    end

    task automatic drive(input logic rst, input logic [2:0] v,
                         input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         input logic [AW-1:0] a2);
        @(posedge clk);
        #1;
        tb_rst    = rst;
        req_valid = v;
        req_addr  = {a2, a1, a0};
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    logic [2:0] rr_seq [6];
    int c0;

    initial begin
        rr_seq = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

        // Grants are suppressed while reset is held.
        drive(1'b1, 3'b111, 12'h001, 12'h002, 12'h003);
        settle();
        chk("rst_ready", 32'(rdy[0]), 0);
        chk("rst_busy", 32'(bsy[0]), 0);
        drive(1'b1, 3'b000, 0, 0, 0);

        // Single request on port 0.
        drive(1'b0, 3'b000, 0, 0, 0);
        drive(1'b0, 3'b001, 12'h123, 12'h456, 12'h789);
        settle();
        chk("s1_ready", 32'(rdy[0]), 32'b001);
        drive(1'b0, 3'b000, 12'h123, 12'h456, 12'h789);
        settle();
        chk("s1_rom_addr", 32'(ra[0]), 32'h123);
        drive(1'b0, 3'b000, 0, 0, 0);
        drive(1'b0, 3'b000, 0, 0, 0);
        settle();
        chk("s1_rsp_valid", 32'(rv[0]), 32'b001);
        chk("s1_rsp_data", 32'(rd[0]), 32'h23);
        drive(1'b0, 3'b000, 0, 0, 0);
        settle();
        chk("s1_busy_low", 32'(bsy[0]), 0);
        chk("s1_l2_rsp_valid", 32'(rv[2]), 32'b001);

        // Port 1 on the two-stage ROM instance.
        drive(1'b0, 3'b010, 0, 12'h07F, 0);
        repeat (4) drive(1'b0, 3'b000, 0, 0, 0);
        settle();
        chk("l2_rsp_valid", 32'(rv[2]), 32'b010);
        chk("l2_rsp_data", 32'(rd[2]), 32'h7F);

        // All ports valid: RR rotates, FIXED sticks to port 0.
        drive(1'b1, 3'b000, 0, 0, 0);
        for (int k = 0; k < 10; k++) begin
            drive(1'b0, 3'b111, 12'h0A1, 12'h0B2, 12'h0C3);
            settle();
            if (k < 6) chk("rr_grant", 32'(rdy[0]), 32'(rr_seq[k]));
            chk("fx_grant", 32'(rdy[1]), 32'b001);
            if (k == 3) begin
                chk("rr_rsp_valid", 32'(rv[0]), 32'b001);
                chk("rr_rsp_data", 32'(rd[0]), 32'h21);
            end
        end
        drive(1'b0, 3'b110, 12'h0A1, 12'h0B2, 12'h0C3);
        settle();
        chk("fx_drop_grant", 32'(rdy[1]), 32'b010);

        // Reset lands exactly when the first in-flight response would appear.
        drive(1'b1, 3'b000, 0, 0, 0);
        drive(1'b0, 3'b011, 12'h011, 12'h022, 12'h033);
        drive(1'b0, 3'b011, 12'h011, 12'h022, 12'h033);
        drive(1'b0, 3'b000, 0, 0, 0);
        drive(1'b1, 3'b000, 0, 0, 0);
        settle();
        chk("flush_rsp_valid", 32'(rv[0]), 0);
        chk("flush_busy", 32'(bsy[0]), 0);
        drive(1'b0, 3'b111, 12'h101, 12'h202, 12'h303);
        settle();
        chk("flush_next_grant", 32'(rdy[0]), 32'b001);
        repeat (6) drive(1'b0, 3'b000, 0, 0, 0);

        // Port 2 sweeps the whole address space and wraps back to 0.
        c0 = cnt2;
        for (int a = 0; a <= 4096; a++) begin
            drive(1'b0, 3'b100, 12'hFFF, 12'hFFF, 12'(a));
        end
        repeat (6) drive(1'b0, 3'b000, 0, 0, 0);
        settle();
        chk("sweep_count", 32'(cnt2 - c0), 32'd4097);

        // Random traffic, including withdrawn requests and idle address churn.
        repeat (400) begin
            drive(1'b0, 3'($urandom), 12'($urandom), 12'($urandom), 12'($urandom));
        end
        repeat (6) drive(1'b0, 3'b000, 0, 0, 0);
        settle();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
